atm_keypad_entry: RTL and testbench
===================================

Name: atm_keypad_entry

Overview:
- Upstream front-end for the ATM controller; converts card insertion plus raw keypad strokes into one complete transaction request.
- Request fields: acc_num, pin, new_pin, amount, operation.
- Assembles BCD PIN digits and decimal amounts, tracks failed-authentication attempts with lockout, and hands each request over on a valid/ready handshake.

Parameters:
- PIN_DIGITS, 4, PIN digits collected; fixed packing into 16 bits, 4 bits per digit.
- AMT_DIGITS, 6, maximum amount digits accepted; extra digits are ignored.
- MAX_TRIES, 3, auth_fail pulses per card session that cause lockout.
- TIMEOUT_CYC, 1024, idle cycles without a key before the session aborts (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- card_in  in  1  level; card present
- card_acc  in  4  account number read from card, sampled on card_in rise
- key_valid  in  1  one-cycle strobe; key_code valid
- key_code  in  4  0-9 digit, 0xA ENTER, 0xB CANCEL, 0xC CLEAR; others ignored
- op_sel  in  3  operation select, sampled on key_valid in S_OP
- auth_fail  in  1  one-cycle pulse from ATM: last PIN rejected
- req_ready  in  1  ATM accepts request
- req_valid  out  1  request pending
- acc_num  out  4  latched account
- pin  out  16  packed BCD PIN, first digit in [15:12]
- new_pin  out  16  packed BCD new PIN (CHANGE_PIN only, else 0)
- amount  out  32  binary amount (WITHDRAW/DEPOSIT only, else 0)
- operation  out  3  3=BALANCE, 4=WITHDRAW, 5=DEPOSIT, 6=CHANGE_PIN
- locked  out  1  lockout active
- entry_state  out  3  current FSM state encoding

Behaviour:
- Reset: all outputs 0; FSM in S_IDLE; fail counter 0; digit counter 0.
- FSM encoding: S_IDLE=0, S_PIN=1, S_OP=2, S_AMT=3, S_NEWPIN=4, S_REQ=5, S_LOCK=6. Registered Moore outputs.
- S_IDLE: on card_in rising edge, latch card_acc into acc_num and clear pin, new_pin, amount → S_PIN.
- S_PIN: each digit key shifts in as pin = {pin[11:0], digit}; the digit counter saturates at PIN_DIGITS and further digits are ignored.
  - ENTER with exactly PIN_DIGITS digits → S_OP; otherwise ENTER is ignored.
  - CLEAR zeroes pin and the digit counter.
- S_OP: key_valid with op_sel equal to 3 → S_REQ; 4 or 5 → S_AMT; 6 → S_NEWPIN; any other op_sel value is ignored. operation is latched on the accepted key.
- S_AMT: each digit updates amount = amount*10 + digit, computed 32-bit truncating; at most AMT_DIGITS digits.
  - ENTER with amount != 0 → S_REQ; ENTER with amount == 0 is ignored.
  - CLEAR zeroes amount.
- S_NEWPIN: same digit and CLEAR rules as S_PIN, applied to new_pin; ENTER with PIN_DIGITS digits → S_REQ.
- S_REQ: req_valid=1; all request fields are held stable until req_ready is sampled high. The handshake completes in the same cycle, then req_valid=0 on the next cycle → S_OP, and amount, new_pin and the digit counter are cleared. Throughput is at most one request per 2 cycles.
- CANCEL in S_PIN, S_OP, S_AMT or S_NEWPIN → S_OP if a PIN has already been entered this session, else → S_PIN; the partial field is cleared.
- auth_fail, any state except S_IDLE and S_LOCK:
  - fail counter +1, pin cleared → S_PIN.
  - If the fail counter reaches MAX_TRIES → S_LOCK and locked=1.
  - An auth_fail arriving in the same cycle as a handshake is applied after the handshake.
- S_LOCK: all keys ignored; exits to S_IDLE only on card_in falling edge. locked is cleared and the fail counter stays 0 for the next card.
- Card removal (card_in low) in any state except S_REQ → S_IDLE next cycle, with all fields and the fail counter cleared. In S_REQ, removal is deferred until the handshake completes, then → S_IDLE.
- Asynchronous reset mid-transaction: immediate return to S_IDLE; any pending request is dropped with no handshake.

Optional Feature:
- Macro ATM_KEY_TIMEOUT_EN.
- Defined:
  - A counter counts cycles in S_PIN, S_OP, S_AMT and S_NEWPIN; it reloads to 0 on any key_valid or state change.
  - Reaching TIMEOUT_CYC → S_IDLE with a card-removal-style clear.
  - Not active in S_REQ, S_LOCK or S_IDLE.
- Undefined: no counter logic is present; sessions never time out.

Test Plan:
- Insert card_acc=5, keys 1,2,3,4,ENTER, op_sel=3, req_ready=1 → req_valid pulse with acc_num=5, pin=16'h1234, operation=3, amount=0.
- PIN 0000, op 4, keys 2,5,0,ENTER, req_ready held low 3 cycles → req_valid held 4 cycles; amount=250 stable throughout; single acceptance.
- op 6, new PIN 9,8,7,6,ENTER → new_pin=16'h9876, operation=6; then S_OP with new_pin cleared.
- Three auth_fail pulses with MAX_TRIES=3 → locked=1, entry_state=6; keys ignored; card_in falls → S_IDLE, locked=0.
- Amount entry 1,2,3,4,5,6,7 with AMT_DIGITS=6 → amount=123456. CLEAR → 0. ENTER with amount 0 → no request.
- With ATM_KEY_TIMEOUT_EN, TIMEOUT_CYC=16: no keys for 16 cycles in S_PIN → S_IDLE, pin=0. Without the macro: stays in S_PIN indefinitely.

Source files
------------

// File: rtl/atm_keypad_entry.sv
// Keypad front-end for the ATM controller: builds one transaction request per handshake.
// Optional idle-session timeout is compiled in with `define ATM_KEY_TIMEOUT_EN.
module atm_keypad_entry #(
    parameter int PIN_DIGITS  = 4,
    parameter int AMT_DIGITS  = 6,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_in,
    input  logic [3:0]  card_acc,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [2:0]  op_sel,
    input  logic        auth_fail,
    input  logic        req_ready,
    output logic        req_valid,
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic [15:0] new_pin,
    output logic [31:0] amount,
    output logic [2:0]  operation,
    output logic        locked,
    output logic [2:0]  entry_state
);

    localparam int CNT_MAX = (AMT_DIGITS > PIN_DIGITS) ? AMT_DIGITS : PIN_DIGITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FAIL_W  = $clog2(MAX_TRIES + 1);

    localparam logic [CNT_W-1:0]  PIN_CNT  = CNT_W'(PIN_DIGITS);
    localparam logic [CNT_W-1:0]  AMT_CNT  = CNT_W'(AMT_DIGITS);
    localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_TRIES);

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hB;
    localparam logic [3:0] KEY_CLEAR  = 4'hC;

    localparam logic [2:0] OP_BALANCE  = 3'd3;
    localparam logic [2:0] OP_WITHDRAW = 3'd4;
    localparam logic [2:0] OP_DEPOSIT  = 3'd5;
    localparam logic [2:0] OP_CHPIN    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PIN    = 3'd1,
        S_OP     = 3'd2,
        S_AMT    = 3'd3,
        S_NEWPIN = 3'd4,
        S_REQ    = 3'd5,
        S_LOCK   = 3'd6
    } state_t;

    state_t              state;
    logic                card_q;
    logic                pin_ok;
    logic [CNT_W-1:0]    dig_cnt;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [FAIL_W-1:0]   fail_next;
    logic                is_digit;
    logic                timeout;

    function automatic logic [15:0] pin_shift(input logic [15:0] p, input logic [3:0] d);
        return {p[11:0], d};
    endfunction

    // Decimal accumulate; wraps modulo 2^32 rather than saturating.
    function automatic logic [31:0] amt_next(input logic [31:0] a, input logic [3:0] d);
        return (a * 32'd10) + {28'd0, d};
    endfunction

    assign is_digit    = (key_code <= 4'd9);
    assign fail_next   = fail_cnt + FAIL_W'(1);
    assign entry_state = state;

`ifdef ATM_KEY_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt;
    state_t          to_state;
    logic            to_active;

    assign to_active = (state == S_PIN) || (state == S_OP) ||
                       (state == S_AMT) || (state == S_NEWPIN);

    // to_state lags state by one cycle so any transition reloads the counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt   <= '0;
            to_state <= S_IDLE;
        end else begin
            to_state <= state;
            if (!to_active || key_valid || (state != to_state))
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout = to_active && !key_valid && (state == to_state) && (to_cnt == TO_LIM);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            card_q    <= 1'b0;
            pin_ok    <= 1'b0;
            dig_cnt   <= '0;
            fail_cnt  <= '0;
            req_valid <= 1'b0;
            acc_num   <= '0;
            pin       <= '0;
            new_pin   <= '0;
            amount    <= '0;
            operation <= '0;
            locked    <= 1'b0;
        end else begin
            card_q <= card_in;
            if (state == S_REQ) begin
                // Fields stay frozen until accepted; removal and auth_fail wait for the handshake.
                if (req_ready) begin
                    req_valid <= 1'b0;
                    amount    <= '0;
                    new_pin   <= '0;
                    dig_cnt   <= '0;
                    if (!card_in) begin
                        state     <= S_IDLE;
                        acc_num   <= '0;
                        pin       <= '0;
                        operation <= '0;
                        locked    <= 1'b0;
                        fail_cnt  <= '0;
                        pin_ok    <= 1'b0;
                    end else if (auth_fail) begin
                        fail_cnt <= fail_next;
                        pin      <= '0;
                        pin_ok   <= 1'b0;
                        if (fail_next >= FAIL_LIM) begin
                            state  <= S_LOCK;
                            locked <= 1'b1;
                        end else begin
                            state <= S_PIN;
                        end
                    end else begin
                        state <= S_OP;
                    end
                end
            end else if ((state != S_IDLE && !card_in) || timeout) begin
                state     <= S_IDLE;
                acc_num   <= '0;
                pin       <= '0;
                new_pin   <= '0;
                amount    <= '0;
                operation <= '0;
                locked    <= 1'b0;
                fail_cnt  <= '0;
                dig_cnt   <= '0;
                pin_ok    <= 1'b0;
                req_valid <= 1'b0;
            end else if (state == S_IDLE) begin
                if (card_in && !card_q) begin
                    state     <= S_PIN;
                    acc_num   <= card_acc;
                    pin       <= '0;
                    new_pin   <= '0;
                    amount    <= '0;
                    operation <= '0;
                    dig_cnt   <= '0;
                    pin_ok    <= 1'b0;
                end
            end else if (state == S_LOCK) begin
                state <= S_LOCK;
            end else if (auth_fail) begin
                fail_cnt <= fail_next;
                pin      <= '0;
                dig_cnt  <= '0;
                pin_ok   <= 1'b0;
                if (fail_next >= FAIL_LIM) begin
                    state  <= S_LOCK;
                    locked <= 1'b1;
                end else begin
                    state <= S_PIN;
                end
            end else if (key_valid) begin
                if (key_code == KEY_CANCEL) begin
                    state   <= pin_ok ? S_OP : S_PIN;
                    dig_cnt <= '0;
                    case (state)
                        S_PIN:    pin     <= '0;
                        S_AMT:    amount  <= '0;
                        S_NEWPIN: new_pin <= '0;
                        default:  ;
                    endcase
                end else begin
                    case (state)
                        S_PIN: begin
                            if (is_digit) begin
                                if (dig_cnt < PIN_CNT) begin
                                    pin     <= pin_shift(pin, key_code);
                                    dig_cnt <= dig_cnt + CNT_W'(1);
                                end
                            end else if (key_code == KEY_ENTER) begin
                                if (dig_cnt == PIN_CNT) begin
                                    state   <= S_OP;
                                    pin_ok  <= 1'b1;
                                    dig_cnt <= '0;
                                end
                            end else if (key_code == KEY_CLEAR) begin
                                pin     <= '0;
                                dig_cnt <= '0;
                            end
                        end
                        S_OP: begin
                            if (op_sel == OP_BALANCE) begin
                                operation <= op_sel;
                                amount    <= '0;
                                new_pin   <= '0;
                                req_valid <= 1'b1;
                                state     <= S_REQ;
                            end else if (op_sel == OP_WITHDRAW || op_sel == OP_DEPOSIT) begin
                                operation <= op_sel;
                                amount    <= '0;
                                new_pin   <= '0;
                                dig_cnt   <= '0;
                                state     <= S_AMT;
                            end else if (op_sel == OP_CHPIN) begin
                                operation <= op_sel;
                                amount    <= '0;
                                new_pin   <= '0;
                                dig_cnt   <= '0;
                                state     <= S_NEWPIN;
                            end
                        end
                        S_AMT: begin
                            if (is_digit) begin
                                if (dig_cnt < AMT_CNT) begin
                                    amount  <= amt_next(amount, key_code);
                                    dig_cnt <= dig_cnt + CNT_W'(1);
                                end
                            end else if (key_code == KEY_ENTER) begin
                                if (amount != 32'd0) begin
                                    req_valid <= 1'b1;
                                    dig_cnt   <= '0;
                                    state     <= S_REQ;
                                end
                            end else if (key_code == KEY_CLEAR) begin
                                amount  <= '0;
                                dig_cnt <= '0;
                            end
                        end
                        S_NEWPIN: begin
                            if (is_digit) begin
                                if (dig_cnt < PIN_CNT) begin
                                    new_pin <= pin_shift(new_pin, key_code);
                                    dig_cnt <= dig_cnt + CNT_W'(1);
                                end
                            end else if (key_code == KEY_ENTER) begin
                                if (dig_cnt == PIN_CNT) begin
                                    req_valid <= 1'b1;
                                    dig_cnt   <= '0;
                                    state     <= S_REQ;
                                end
                            end else if (key_code == KEY_CLEAR) begin
                                new_pin <= '0;
                                dig_cnt <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Scoreboard bench for atm_keypad_entry: directed sessions, queued expected requests.
module tb_atm_keypad_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic        card_in;
    logic [3:0]  card_acc;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [2:0]  op_sel;
    logic        auth_fail;
    logic        req_ready;
    logic        req_valid;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic [31:0] amount;
    logic [2:0]  operation;
    logic        locked;
    logic [2:0]  entry_state;

    typedef struct packed {
        logic [3:0]  acc;
        logic [15:0] pin;
        logic [15:0] npin;
        logic [31:0] amt;
        logic [2:0]  op;
    } req_t;

    req_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    atm_keypad_entry #(
        .PIN_DIGITS(4), .AMT_DIGITS(6), .MAX_TRIES(3), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .card_in(card_in), .card_acc(card_acc),
        .key_valid(key_valid), .key_code(key_code), .op_sel(op_sel),
        .auth_fail(auth_fail), .req_ready(req_ready), .req_valid(req_valid),
        .acc_num(acc_num), .pin(pin), .new_pin(new_pin), .amount(amount),
        .operation(operation), .locked(locked), .entry_state(entry_state)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle a request is presented it must match the queue head.
    always @(negedge clk) begin
        if (rst && req_valid) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_req: got acc=%0h pin=%h op=%0d, required no request",
                         acc_num, pin, operation);
            end else begin
                if ({acc_num, pin, new_pin, amount, operation} !== sb_q[0]) begin
                    n_fail++;
                    $display("FAIL req_fields: got acc=%0h pin=%h npin=%h amt=%0d op=%0d, required acc=%0h pin=%h npin=%h amt=%0d op=%0d",
                             acc_num, pin, new_pin, amount, operation,
                             sb_q[0].acc, sb_q[0].pin, sb_q[0].npin, sb_q[0].amt, sb_q[0].op);
                end
                if (req_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
    endtask

    task automatic sel_op(input logic [2:0] o);
        op_sel = o;
        press(4'hF);
    endtask

    task automatic fail_pulse();
        auth_fail = 1'b1;
        tick();
        auth_fail = 1'b0;
        tick();
    endtask

    task automatic enter_pin(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d); press(4'hA);
    endtask

    initial begin
        rst = 1'b0; card_in = 1'b0; card_acc = 4'd0; key_valid = 1'b0;
        key_code = 4'd0; op_sel = 3'd0; auth_fail = 1'b0; req_ready = 1'b0;
        tick(); tick();
        chk("rst_state", 32'(entry_state), 32'd0);
        chk("rst_valid", 32'(req_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_fields", {28'd0, acc_num} | 32'(pin) | 32'(new_pin) | amount | 32'(operation), 32'd0);
        rst = 1'b1;
        tick();

        // Balance request, ready already high
        card_acc = 4'd5; card_in = 1'b1; tick();
        chk("card_to_pin", 32'(entry_state), 32'd1);
        chk("acc_latch", 32'(acc_num), 32'd5);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("pin_packed", 32'(pin), 32'h1234);
        press(4'hA);
        chk("pin_enter", 32'(entry_state), 32'd2);
        req_ready = 1'b1;
        sb_q.push_back('{acc: 4'd5, pin: 16'h1234, npin: 16'h0, amt: 32'd0, op: 3'd3});
        sel_op(3'd3);
        chk("bal_back_op", 32'(entry_state), 32'd2);
        chk("bal_valid_low", 32'(req_valid), 32'd0);
        req_ready = 1'b0;

        // New card: withdraw 250 with a stalled handshake
        card_in = 1'b0; tick();
        chk("remove_idle", 32'(entry_state), 32'd0);
        chk("remove_acc", 32'(acc_num), 32'd0);
        card_acc = 4'd9; card_in = 1'b1; tick();
        enter_pin(4'd0, 4'd0, 4'd0, 4'd0);
        chk("pin0_op", 32'(entry_state), 32'd2);
        sel_op(3'd4);
        chk("wd_amt_state", 32'(entry_state), 32'd3);
        press(4'd2); press(4'd5); press(4'd0);
        chk("amt_250", amount, 32'd250);
        sb_q.push_back('{acc: 4'd9, pin: 16'h0000, npin: 16'h0, amt: 32'd250, op: 3'd4});
        press(4'hA);
        for (int i = 0; i < 3; i++) begin
            chk("wd_hold_valid", 32'(req_valid), 32'd1);
            chk("wd_hold_amt", amount, 32'd250);
            if (i < 2) tick();
        end
        req_ready = 1'b1;
        tick();
        chk("wd_done_valid", 32'(req_valid), 32'd0);
        chk("wd_done_state", 32'(entry_state), 32'd2);
        chk("wd_single_accept", 32'(sb_q.size()), 32'd0);
        req_ready = 1'b0;

        // Change PIN
        sel_op(3'd6);
        chk("np_state", 32'(entry_state), 32'd4);
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        chk("np_value", 32'(new_pin), 32'h9876);
        req_ready = 1'b1;
        sb_q.push_back('{acc: 4'd9, pin: 16'h0000, npin: 16'h9876, amt: 32'd0, op: 3'd6});
        press(4'hA);
        chk("np_back_op", 32'(entry_state), 32'd2);
        chk("np_cleared", 32'(new_pin), 32'd0);
        req_ready = 1'b0;

        // Deposit: digit limit, CLEAR, ENTER on zero
        sel_op(3'd5);
        chk("dep_op", 32'(operation), 32'd5);
        for (int d = 1; d <= 7; d++) press(4'(d));
        chk("amt_limit", amount, 32'd123456);
        press(4'hC);
        chk("amt_clear", amount, 32'd0);
        press(4'hA);
        chk("amt_zero_enter", 32'(entry_state), 32'd3);
        chk("amt_zero_noreq", 32'(req_valid), 32'd0);
        press(4'hB);
        chk("cancel_to_op", 32'(entry_state), 32'd2);

        // Lockout after three failures
        fail_pulse();
        chk("fail1_state", 32'(entry_state), 32'd1);
        chk("fail1_pin", 32'(pin), 32'd0);
        fail_pulse();
        chk("fail2_locked", 32'(locked), 32'd0);
        fail_pulse();
        chk("fail3_state", 32'(entry_state), 32'd6);
        chk("fail3_locked", 32'(locked), 32'd1);
        press(4'd1);
        chk("lock_key_ign", 32'(pin), 32'd0);
        chk("lock_stays", 32'(entry_state), 32'd6);
        card_in = 1'b0; tick();
        chk("unlock_state", 32'(entry_state), 32'd0);
        chk("unlock_flag", 32'(locked), 32'd0);
        card_acc = 4'd3; card_in = 1'b1; tick();
        fail_pulse();
        chk("newcard_fail1", 32'(locked), 32'd0);
        chk("newcard_state", 32'(entry_state), 32'd1);

        // PIN cancel, digit saturation
        press(4'd1); press(4'd2);
        press(4'hB);
        chk("pin_cancel", 32'(pin), 32'd0);
        chk("pin_cancel_st", 32'(entry_state), 32'd1);
        press(4'd5); press(4'd6); press(4'd7); press(4'd8); press(4'd9);
        chk("pin_saturate", 32'(pin), 32'h5678);

        // Idle in S_PIN
        fail_pulse();
        for (int i = 0; i < 8; i++) tick();
        chk("idle_short", 32'(entry_state), 32'd1);
        for (int i = 0; i < 30; i++) tick();
`ifdef ATM_KEY_TIMEOUT_EN
        chk("timeout_state", 32'(entry_state), 32'd0);
        chk("timeout_pin", 32'(pin), 32'd0);
`else
        chk("no_timeout", 32'(entry_state), 32'd1);
`endif

        // Async reset drops a pending request
        card_in = 1'b0; tick();
        card_acc = 4'd7; card_in = 1'b1; tick();
        enter_pin(4'd1, 4'd1, 4'd1, 4'd1);
        sb_q.push_back('{acc: 4'd7, pin: 16'h1111, npin: 16'h0, amt: 32'd0, op: 3'd3});
        sel_op(3'd3);
        chk("pre_rst_valid", 32'(req_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_state", 32'(entry_state), 32'd0);
        chk("mid_rst_valid", 32'(req_valid), 32'd0);
        sb_q.delete();
        card_in = 1'b0;
        tick();
        rst = 1'b1;
        tick(); tick();
        chk("end_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
